// File: rtl/fp_sub_1d5_arb.sv
// Two-requester round-robin arbiter in front of a fixed-latency 1.5-subtract pipe.
// Optional tag/strobe consistency check: define FP_SUB_ARB_ERRCHK_EN.
module fp_sub_1d5_arb #(
    parameter int PIPE_LAT = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        a_valid,
    input  logic        b_valid,
    input  logic [30:0] a_in,
    input  logic [30:0] a_in_delay,
    input  logic [30:0] b_in,
    input  logic [30:0] b_in_delay,
    output logic        a_ready,
    output logic        b_ready,
    output logic        pipe_valid,
    output logic [30:0] pipe_in,
    output logic [30:0] pipe_in_delay,
    input  logic [30:0] pipe_out,
    input  logic [30:0] pipe_out_delay,
    input  logic        pipe_ready,
    output logic        res_valid_a,
    output logic        res_valid_b,
    output logic [30:0] res_out,
    output logic [30:0] res_out_delay,
    output logic        busy,
    output logic        err
);

    logic              prio_b_q, prio_b_d;
    logic              pv_q, pv_d;
    logic [30:0]       pin_q, pin_d;
    logic [30:0]       pind_q, pind_d;
    logic [PIPE_LAT:0] tv_q, tv_d;
    logic [PIPE_LAT:0] to_q, to_d;
    logic              rva_q, rva_d;
    logic              rvb_q, rvb_d;
    logic [30:0]       ro_q, ro_d;
    logic [30:0]       rod_q, rod_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              xfer;
    logic              hit;

    // prio_b_q set means B wins a tie (A was granted last)
    always_comb begin
        a_ready = rst_n & en & a_valid & (~b_valid | ~prio_b_q);
        b_ready = rst_n & en & b_valid & (~a_valid | prio_b_q);
        xfer    = (a_valid & a_ready) | (b_valid & b_ready);
        hit     = pipe_ready & tv_q[PIPE_LAT];
    end

    always_comb begin
        prio_b_d = prio_b_q;
        pin_d    = pin_q;
        pind_d   = pind_q;
        if (xfer) begin
            prio_b_d = ~b_ready;
            pin_d    = b_ready ? b_in : a_in;
            pind_d   = b_ready ? b_in_delay : a_in_delay;
        end
        pv_d  = xfer;
        tv_d  = {tv_q[PIPE_LAT-1:0], xfer};
        to_d  = {to_q[PIPE_LAT-1:0], b_ready};
        rva_d = hit & ~to_q[PIPE_LAT];
        rvb_d = hit & to_q[PIPE_LAT];
        ro_d  = hit ? pipe_out : ro_q;
        rod_d = hit ? pipe_out_delay : rod_q;
        cnt_d = cnt_q;
        unique case ({xfer, rva_q | rvb_q})
            2'b10:   cnt_d = cnt_q + 4'd1;
            2'b01:   cnt_d = cnt_q - 4'd1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prio_b_q <= 1'b0;
            pv_q     <= 1'b0;
            pin_q    <= '0;
            pind_q   <= '0;
            tv_q     <= '0;
            to_q     <= '0;
            rva_q    <= 1'b0;
            rvb_q    <= 1'b0;
            ro_q     <= '0;
            rod_q    <= '0;
            cnt_q    <= '0;
        end else begin
            prio_b_q <= prio_b_d;
            pv_q     <= pv_d;
            pin_q    <= pin_d;
            pind_q   <= pind_d;
            tv_q     <= tv_d;
            to_q     <= to_d;
            rva_q    <= rva_d;
            rvb_q    <= rvb_d;
            ro_q     <= ro_d;
            rod_q    <= rod_d;
            cnt_q    <= cnt_d;
        end
    end

    assign pipe_valid    = pv_q;
    assign pipe_in       = pin_q;
    assign pipe_in_delay = pind_q;
    assign res_valid_a   = rva_q;
    assign res_valid_b   = rvb_q;
    assign res_out       = ro_q;
    assign res_out_delay = rod_q;
    assign busy          = (cnt_q != 4'd0);

`ifdef FP_SUB_ARB_ERRCHK_EN
    localparam logic [3:0] MASK_INIT = 4'(PIPE_LAT + 1);

    logic [3:0] mask_q, mask_d;
    logic       err_q, err_d;

    // strobes of ops discarded by reset can still land during the mask window
    always_comb begin
        mask_d = mask_q;
        if (mask_q != 4'd0) mask_d = mask_q - 4'd1;
        err_d = err_q | ((mask_q == 4'd0) & (pipe_ready ^ tv_q[PIPE_LAT]));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mask_q <= MASK_INIT;
            err_q  <= 1'b0;
        end else begin
            mask_q <= mask_d;
            err_q  <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_fp_sub_1d5_arb.sv
// Randomized bench for fp_sub_1d5_arb with a transaction-level reference model
// and a fixed-latency pipe model driving pipe_ready/pipe_out.
module tb_fp_sub_1d5_arb;

    localparam int PL = 2;
`ifdef FP_SUB_ARB_ERRCHK_EN
    localparam bit ERRCHK = 1'b1;
`else
    localparam bit ERRCHK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n, en, a_valid, b_valid;
    logic [30:0] a_in, a_in_delay, b_in, b_in_delay;
    logic        a_ready, b_ready, pipe_valid;
    logic [30:0] pipe_in, pipe_in_delay;
    logic [30:0] pipe_out, pipe_out_delay;
    logic        pipe_ready;
    logic        res_valid_a, res_valid_b;
    logic [30:0] res_out, res_out_delay;
    logic        busy, err;

    always #5 clk = ~clk;

    fp_sub_1d5_arb #(.PIPE_LAT(PL)) dut (
        .clk(clk), .rst_n(rst_n), .en(en),
        .a_valid(a_valid), .b_valid(b_valid),
        .a_in(a_in), .a_in_delay(a_in_delay),
        .b_in(b_in), .b_in_delay(b_in_delay),
        .a_ready(a_ready), .b_ready(b_ready),
        .pipe_valid(pipe_valid), .pipe_in(pipe_in), .pipe_in_delay(pipe_in_delay),
        .pipe_out(pipe_out), .pipe_out_delay(pipe_out_delay), .pipe_ready(pipe_ready),
        .res_valid_a(res_valid_a), .res_valid_b(res_valid_b),
        .res_out(res_out), .res_out_delay(res_out_delay),
        .busy(busy), .err(err)
    );

    typedef struct {
        int          iss;
        bit          own;
        logic [30:0] d;
        logic [30:0] dd;
    } op_t;

    int          ntot = 0;
    int          npass = 0;
    int          cyc = 0;
    int          ms = 0;
    op_t         q[$];
    bit          prio_b = 0;
    bit          pv_e = 0;
    bit          err_e = 0;
    logic [30:0] pin_e = '0, pind_e = '0, ro_e = '0, rod_e = '0;
    bit          sv[16];
    logic [30:0] so[16], sod[16];

    function automatic logic [30:0] sub15(input logic [30:0] x);
        return x - 31'h0060_0000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntot++;
        if (obs !== exp)
            $display("FAIL %s cyc=%0d got=%h want=%h", tag, cyc, obs, exp);
        else
            npass++;
    endtask

    task automatic step(input bit r, input bit e, input bit av, input bit bv,
                        input logic [30:0] a, input logic [30:0] ad,
                        input logic [30:0] b, input logic [30:0] bd,
                        input bit inj);
        bit ga, gb, ea, eb, bz, slot;
        op_t o;
        rst_n = r; en = e; a_valid = av; b_valid = bv;
        a_in = a; a_in_delay = ad; b_in = b; b_in_delay = bd;
        pipe_ready     = sv[cyc % 16] | inj;
        pipe_out       = so[cyc % 16];
        pipe_out_delay = sod[cyc % 16];
        sv[cyc % 16]   = 1'b0;
        @(negedge clk);
        ga = r && e && av && (!bv || !prio_b);
        gb = r && e && bv && (!av || prio_b);
        ea = 0; eb = 0; bz = 0; slot = 0;
        foreach (q[i]) begin
            if (q[i].iss + PL + 2 == cyc) begin
                if (q[i].own) eb = 1; else ea = 1;
                ro_e  = sub15(q[i].d);
                rod_e = q[i].dd;
            end
            if (q[i].iss < cyc && cyc <= q[i].iss + PL + 2) bz = 1;
            if (q[i].iss + PL + 1 == cyc) slot = 1;
        end
        chk("a_ready", 32'(a_ready), 32'(ga));
        chk("b_ready", 32'(b_ready), 32'(gb));
        chk("pipe_valid", 32'(pipe_valid), 32'(pv_e));
        chk("pipe_in", 32'(pipe_in), 32'(pin_e));
        chk("pipe_in_delay", 32'(pipe_in_delay), 32'(pind_e));
        chk("res_valid_a", 32'(res_valid_a), 32'(ea));
        chk("res_valid_b", 32'(res_valid_b), 32'(eb));
        chk("res_out", 32'(res_out), 32'(ro_e));
        chk("res_out_delay", 32'(res_out_delay), 32'(rod_e));
        chk("busy", 32'(busy), 32'(bz));
        chk("err", 32'(err), 32'(err_e));
        if (pipe_valid === 1'b1) begin
            sv[(cyc + PL) % 16]  = 1'b1;
            so[(cyc + PL) % 16]  = sub15(pipe_in);
            sod[(cyc + PL) % 16] = pipe_in_delay;
        end
        if (!r) begin
            q.delete();
            prio_b = 0; pv_e = 0; err_e = 0; ms = 0;
            pin_e = '0; pind_e = '0; ro_e = '0; rod_e = '0;
        end else begin
            if (ms >= PL + 1 && (pipe_ready != slot)) err_e = err_e | ERRCHK;
            ms++;
            pv_e = ga | gb;
            if (ga | gb) begin
                o.iss = cyc; o.own = gb;
                o.d   = gb ? b : a;
                o.dd  = gb ? bd : ad;
                q.push_back(o);
                pin_e  = o.d;
                pind_e = o.dd;
                prio_b = ga;
            end
            while (q.size() > 0 && q[0].iss + PL + 2 <= cyc) void'(q.pop_front());
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1, 1, 0, 0, '0, '0, '0, '0, 0);
    endtask

    task automatic rnd(input bit r, input bit e, input bit av, input bit bv);
        step(r, e, av, bv, 31'($urandom), 31'($urandom),
             31'($urandom), 31'($urandom), 0);
    endtask

    initial begin
        foreach (sv[i]) begin
            sv[i] = 1'b0; so[i] = '0; sod[i] = '0;
        end
        rst_n = 0; en = 0; a_valid = 0; b_valid = 0;
        a_in = '0; a_in_delay = '0; b_in = '0; b_in_delay = '0;
        pipe_ready = 0; pipe_out = '0; pipe_out_delay = '0;
        repeat (3) @(posedge clk);
        #1;

        step(1, 1, 1, 0, 31'h3F80_0000, 31'h0001_2345, '0, '0, 0);
        idle(6);

        repeat (6) rnd(1, 1, 1, 1);
        idle(6);

        repeat (3) rnd(1, 0, 1, 1);
        rnd(0, 0, 1, 1);
        repeat (2) rnd(1, 0, 1, 1);
        rnd(1, 1, 1, 1);
        idle(6);

        rnd(1, 1, 1, 0);
        rnd(1, 1, 0, 1);
        idle(1);
        rnd(0, 1, 0, 0);
        idle(8);

        for (int i = 0; i < 400; i++)
            rnd($urandom_range(0, 49) != 0, $urandom_range(0, 6) != 0,
                $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6);
        idle(8);

        rnd(0, 0, 0, 0);
        idle(10);
        step(1, 1, 0, 0, '0, '0, '0, '0, 1);
        idle(5);
        rnd(0, 0, 0, 0);
        idle(3);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout cyc=%0d", cyc);
        $fatal(1);
    end

endmodule
